// File: rtl/cache_assoc_nway.sv
// N-way set-associative write-back, write-allocate cache with true-LRU ages.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_assoc_nway #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 5,
    parameter int SET_BITS = 1,
    parameter int WAYS     = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int TAG_W = ADDR_W - SET_BITS;
    localparam int SETS  = 1 << SET_BITS;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              hit_flag_q, hit_flag_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic              cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              hit_q, hit_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              line_valid_q [SETS][WAYS];
    logic              line_dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]  line_tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] line_data_q  [SETS][WAYS];
    logic [WAY_W-1:0]  line_age_q   [SETS][WAYS];

    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic [WAYS-1:0]     way_hit;
    logic [WAYS-1:0]     way_inv;
    logic [WAYS-1:0]     way_old;
    logic                any_hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim_way;
    logic                mem_done;

    logic                acc_en;
    logic [WAY_W-1:0]    acc_way;
    logic                line_we;
    logic                line_dirty;
    logic [DATA_W-1:0]   line_wdata;

    assign idx      = addr_q[ADDR_W-1 -: SET_BITS];
    assign tag      = addr_q[TAG_W-1:0];
    assign mem_done = mem_req_q && mem_ready;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign way_hit[gi] = line_valid_q[idx][gi] && (line_tag_q[idx][gi] == tag);
        assign way_inv[gi] = !line_valid_q[idx][gi];
        assign way_old[gi] = (line_age_q[idx][gi] == WAY_W'(WAYS - 1));
    end

    // Invalid ways take priority over the LRU way; descending loops pick the lowest index.
    always_comb begin
        hit_way    = '0;
        victim_way = '0;
        any_hit    = |way_hit;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) hit_way = WAY_W'(i);
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_old[i]) victim_way = WAY_W'(i);
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_inv[i]) victim_way = WAY_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        victim_d    = victim_q;
        hit_flag_d  = hit_flag_q;
        resp_data_d = resp_data_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        hit_d       = hit_q;
        mem_req_d   = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        acc_en      = 1'b0;
        acc_way     = victim_q;
        line_we     = 1'b0;
        line_dirty  = 1'b0;
        line_wdata  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    write_d = cpu_write;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_flag_d = any_hit;
                victim_d   = victim_way;
                if (any_hit) begin
                    acc_en  = 1'b1;
                    acc_way = hit_way;
                    if (write_q) begin
                        line_we     = 1'b1;
                        line_dirty  = 1'b1;
                        resp_data_d = wdata_q;
                    end else begin
                        resp_data_d = line_data_q[idx][hit_way];
                    end
                    state_d = ST_RESP;
                end else if (line_valid_q[idx][victim_way] && line_dirty_q[idx][victim_way]) begin
                    state_d = ST_WRITEBACK;
                end else if (!write_q) begin
                    state_d = ST_REFILL;
                end else begin
                    acc_en      = 1'b1;
                    acc_way     = victim_way;
                    line_we     = 1'b1;
                    line_dirty  = 1'b1;
                    resp_data_d = wdata_q;
                    state_d     = ST_RESP;
                end
            end
            ST_WRITEBACK: begin
                if (mem_done) begin
                    if (write_q) begin
                        acc_en      = 1'b1;
                        line_we     = 1'b1;
                        line_dirty  = 1'b1;
                        resp_data_d = wdata_q;
                        state_d     = ST_RESP;
                    end else begin
                        // Hand straight over to the refill request without a gap cycle.
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_q;
                        state_d    = ST_REFILL;
                    end
                end else begin
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {idx, line_tag_q[idx][victim_q]};
                    mem_wdata_d = line_data_q[idx][victim_q];
                end
            end
            ST_REFILL: begin
                if (mem_done) begin
                    acc_en      = 1'b1;
                    line_we     = 1'b1;
                    line_wdata  = mem_rdata;
                    resp_data_d = mem_rdata;
                    state_d     = ST_RESP;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_q;
                end
            end
            ST_RESP: begin
                cpu_ready_d = 1'b1;
                cpu_rdata_d = resp_data_q;
                hit_d       = hit_flag_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            victim_q    <= '0;
            hit_flag_q  <= 1'b0;
            resp_data_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            hit_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            victim_q    <= victim_d;
            hit_flag_q  <= hit_flag_d;
            resp_data_q <= resp_data_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            hit_q       <= hit_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Ages stay a permutation: the accessed way goes to 0, younger ways age by one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    line_valid_q[s][w] <= 1'b0;
                    line_dirty_q[s][w] <= 1'b0;
                    line_tag_q[s][w]   <= '0;
                    line_data_q[s][w]  <= '0;
                    line_age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else if (acc_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == acc_way) begin
                    line_age_q[idx][w] <= '0;
                end else if (line_age_q[idx][w] < line_age_q[idx][acc_way]) begin
                    line_age_q[idx][w] <= line_age_q[idx][w] + WAY_W'(1);
                end
            end
            if (line_we) begin
                line_valid_q[idx][acc_way] <= 1'b1;
                line_dirty_q[idx][acc_way] <= line_dirty;
                line_tag_q[idx][acc_way]   <= tag;
                line_data_q[idx][acc_way]  <= line_wdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == ST_RESP) begin
            if (hit_flag_q) begin
                if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign hit       = hit_q;
    assign mem_req   = mem_req_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_assoc_nway.sv
// Scoreboard bench for cache_assoc_nway: directed requests push expected CPU responses
// and memory transactions; a response monitor and a memory model pop and compare them.
module tb_cache_assoc_nway;

    localparam int AW = 5;
    localparam int DW = 5;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          h;
    } rsp_t;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } mem_t;

    logic          clock;
    logic          reset_n;
    logic          cpu_req;
    logic          cpu_write;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          hit;
    logic          mem_req;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;
`endif

    rsp_t exp_rsp_q[$];
    mem_t exp_mem_q[$];
    logic [DW-1:0] mem_model [32];
    int n_pass;
    int n_total;
    int mem_lat;
    bit stall_chk;

    cache_assoc_nway dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    endfunction

    task automatic exp_mem(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_t m;
        m.w = w;
        m.a = a;
        m.d = d;
        exp_mem_q.push_back(m);
    endtask

    task automatic wait_ready(output int lat);
        lat = 1;
        while (cpu_ready !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check("rsp_arrived", {31'd0, cpu_ready}, 32'd1);
        check("mem_pending", exp_mem_q.size(), 0);
    endtask

    // Issue one request; latency counts negedges from the sampling edge to cpu_ready.
    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_d, input logic exp_h, output int lat);
        rsp_t r;
        @(negedge clock);
        r.a = a;
        r.d = exp_d;
        r.h = exp_h;
        exp_rsp_q.push_back(r);
        cpu_req   = 1'b1;
        cpu_write = w;
        cpu_addr  = a;
        cpu_wdata = d;
        @(negedge clock);
        cpu_req = 1'b0;
        wait_ready(lat);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cpu_ready"}, {31'd0, cpu_ready}, 32'd0);
        check({tag, "_hit"},       {31'd0, hit}, 32'd0);
        check({tag, "_mem_req"},   {31'd0, mem_req}, 32'd0);
        check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
        check({tag, "_cpu_rdata"}, {27'd0, cpu_rdata}, 32'd0);
        check({tag, "_mem_addr"},  {27'd0, mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, {27'd0, mem_wdata}, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        exp_rsp_q.delete();
        exp_mem_q.delete();
        reset_n = 1'b1;
    endtask

    // Response monitor.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && cpu_ready === 1'b1) begin
                if (exp_rsp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_rsp: got rdata=0x%0h hit=%0b, required no response",
                             cpu_rdata, hit);
                end else begin
                    e = exp_rsp_q.pop_front();
                    $display("rsp addr=0x%0h rdata=0x%0h hit=%0b", e.a, cpu_rdata, hit);
                    check("rsp_rdata", {27'd0, cpu_rdata}, {27'd0, e.d});
                    check("rsp_hit", {31'd0, hit}, {31'd0, e.h});
                end
            end
        end
    end

    // Memory model: compares each request against the expected queue, then answers after mem_lat cycles.
    initial begin
        mem_t e;
        logic t_write;
        logic [AW-1:0] t_addr;
        logic [DW-1:0] t_wdata;
        bit stable;
        bit aborted;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && mem_req === 1'b1) begin
                t_write = mem_write;
                t_addr  = mem_addr;
                t_wdata = mem_wdata;
                $display("mem %s addr=0x%0h wdata=0x%0h", t_write ? "wr" : "rd", t_addr, t_wdata);
                if (exp_mem_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_mem_req: got addr=0x%0h write=%0b, required no request",
                             t_addr, t_write);
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_write", {31'd0, t_write}, {31'd0, e.w});
                    check("mem_addr", {27'd0, t_addr}, {27'd0, e.a});
                    if (e.w) check("mem_wdata", {27'd0, t_wdata}, {27'd0, e.d});
                end
                stable  = 1'b1;
                aborted = 1'b0;
                for (int i = 0; i < mem_lat; i++) begin
                    @(negedge clock);
                    if (reset_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (mem_req !== 1'b1 || mem_addr !== t_addr || mem_write !== t_write)
                        stable = 1'b0;
                end
                if (!aborted) begin
                    mem_rdata = mem_model[t_addr];
                    mem_ready = 1'b1;
                    @(negedge clock);
                    mem_ready = 1'b0;
                    if (t_write) mem_model[t_addr] = t_wdata;
                    if (stall_chk) check("mem_stable", {31'd0, stable}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        n_pass    = 0;
        n_total   = 0;
        mem_lat   = 2;
        stall_chk = 1'b0;
        cpu_req   = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        reset_n   = 1'b1;
        for (int i = 0; i < 32; i++) mem_model[i] = '0;
        mem_model[5'h03] = 5'h15;
        mem_model[5'h05] = 5'h0C;
        mem_model[5'h07] = 5'h11;
        mem_model[5'h09] = 5'h06;
        mem_model[5'h12] = 5'h07;
        mem_model[5'h14] = 5'h1B;
        mem_model[5'h16] = 5'h19;

        #1 reset_n = 1'b0;
        #3;
        check_outputs_zero("reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Read miss then hit.
        exp_mem(1'b0, 5'h03, 5'h00);
        do_req(1'b0, 5'h03, 5'h00, 5'h15, 1'b0, lat);
        do_req(1'b0, 5'h03, 5'h00, 5'h15, 1'b1, lat);
        check("hit_latency", lat, 3);

`ifdef CACHE_STATS_EN
        @(negedge clock);
        check("hit_count", {16'd0, hit_count}, 32'd1);
        check("miss_count", {16'd0, miss_count}, 32'd1);
        force dut.hit_count_q = 16'hFFFF;
        @(negedge clock);
        release dut.hit_count_q;
        do_req(1'b0, 5'h03, 5'h00, 5'h15, 1'b1, lat);
        @(negedge clock);
        check("hit_count_sat", {16'd0, hit_count}, 32'h0000FFFF);
`endif

        // LRU replacement and dirty write-back.
        do_req(1'b0, 5'h03, 5'h00, 5'h15, 1'b1, lat);
        exp_mem(1'b0, 5'h05, 5'h00);
        do_req(1'b0, 5'h05, 5'h00, 5'h0C, 1'b0, lat);
        do_req(1'b1, 5'h03, 5'h0A, 5'h0A, 1'b1, lat);
        exp_mem(1'b0, 5'h07, 5'h00);
        do_req(1'b0, 5'h07, 5'h00, 5'h11, 1'b0, lat);
        exp_mem(1'b1, 5'h03, 5'h0A);
        exp_mem(1'b0, 5'h09, 5'h00);
        do_req(1'b0, 5'h09, 5'h00, 5'h06, 1'b0, lat);
        exp_mem(1'b0, 5'h03, 5'h00);
        do_req(1'b0, 5'h03, 5'h00, 5'h0A, 1'b0, lat);

        // Write miss into an invalid way installs without memory traffic.
        apply_reset();
        do_req(1'b1, 5'h12, 5'h1F, 5'h1F, 1'b0, lat);
        do_req(1'b0, 5'h12, 5'h00, 5'h1F, 1'b1, lat);
        check("hit_latency_wr", lat, 3);

        // Stalled refill with ignored cpu_req pulses.
        mem_lat   = 5;
        stall_chk = 1'b1;
        exp_mem(1'b0, 5'h14, 5'h00);
        begin
            rsp_t r;
            @(negedge clock);
            r.a = 5'h14;
            r.d = 5'h1B;
            r.h = 1'b0;
            exp_rsp_q.push_back(r);
            cpu_req   = 1'b1;
            cpu_write = 1'b0;
            cpu_addr  = 5'h14;
            @(negedge clock);
            cpu_req = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                cpu_req   = (i % 2 == 0);
                cpu_write = 1'b1;
                cpu_addr  = 5'h0B;
                cpu_wdata = 5'h04;
            end
            cpu_req = 1'b0;
            wait_ready(lat);
        end
        repeat (6) @(negedge clock);
        check("stall_rsp_pending", exp_rsp_q.size(), 0);
        stall_chk = 1'b0;

        // Reset in the middle of a write-back.
        exp_mem(1'b1, 5'h12, 5'h1F);
        exp_mem(1'b0, 5'h16, 5'h00);
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 5'h16;
        @(negedge clock);
        cpu_req = 1'b0;
        cnt = 0;
        while (mem_req !== 1'b1 && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        check("wb_started", {31'd0, mem_req}, 32'd1);
        check("wb_is_write", {31'd0, mem_write}, 32'd1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clock);
        exp_rsp_q.delete();
        exp_mem_q.delete();
        reset_n = 1'b1;
        mem_lat = 2;
        exp_mem(1'b0, 5'h12, 5'h00);
        do_req(1'b0, 5'h12, 5'h00, 5'h07, 1'b0, lat);

        repeat (5) @(negedge clock);
        check("final_rsp_pending", exp_rsp_q.size(), 0);
        check("final_mem_pending", exp_mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_assoc_nway.md
# cache_assoc_nway

Parametrised N-way set-associative write-back cache with write-allocate and true-LRU replacement. It sits between the board-level circuit (CPU side) and the word-addressed RAM (memory side). Both sides use a registered request/ready handshake, so memory latency is arbitrary. One data word per line; dirty victims are written back before a refill.

## Interface
- `ADDR_W`, 5: address width.
- `DATA_W`, 5: data word / line width.
- `SET_BITS`, 1: log2 of set count; index = `addr[ADDR_W-1 -: SET_BITS]`, tag = `addr[ADDR_W-SET_BITS-1:0]`.
- `WAYS`, 2: associativity, legal values 2 or 4.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: request valid, sampled only in IDLE.
- `cpu_write` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: request address.
- `cpu_wdata` in DATA_W: write data.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_rdata` out DATA_W: read data (write data on writes), valid with `cpu_ready`.
- `hit` out 1: 1 if the request hit; valid with `cpu_ready`, held until the next response.
- `mem_req` out 1: memory request.
- `mem_write` out 1: 1 = write-back, 0 = refill.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: write-back data.
- `mem_ready` in 1: memory completion; ignored while `mem_req`=0.
- `mem_rdata` in DATA_W: refill data, sampled with `mem_ready`.

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESP.
- IDLE: on `cpu_req`=1, capture addr/wdata/write, go to LOOKUP. `cpu_req` is ignored in all other states.
- LOOKUP: compare tag against all valid ways of the set.
  - Hit: reads return line data. Writes store wdata and set dirty. Go to RESP.
  - Miss: victim = lowest-index invalid way, else the way with age WAYS-1.
    - Victim valid and dirty: go to WRITEBACK.
    - Read: go to REFILL.
    - Write: install line (valid, dirty, data = wdata) with no memory access, go to RESP.
- WRITEBACK: `mem_req`=1, `mem_write`=1, `mem_addr` = {index, victim tag}, `mem_wdata` = victim data. On `mem_ready`: a read goes to REFILL; a write installs the line dirty and goes to RESP.
- REFILL: `mem_req`=1, `mem_write`=0, `mem_addr` = captured addr. On `mem_ready`: install line (valid, clean, `mem_rdata`), go to RESP.
- RESP: `cpu_ready`=1 for exactly one cycle, return to IDLE.
- LRU: per-line age of log2(WAYS) bits, always a permutation within a set.
  - On access of way w with age a: w's age becomes 0; every way with age < a increments.
  - Reset age of way i = i.
- Only one line is modified per request; a write-back completing on the same edge as reset is not completed.

## Timing
- Reset values:
  - Outputs: `cpu_ready`, `hit`, `mem_req`, `mem_write` = 0; `cpu_rdata`, `mem_addr`, `mem_wdata` = 0.
  - Array: all lines invalid and clean.
  - FSM: IDLE.
- All outputs are registered.
- Hit latency: request sampled at edge E0; `cpu_ready` high after E2, for one cycle. Next request can be accepted at E3.
- Miss latency: `mem_req` rises after E2. Completion is 1 cycle after each `mem_ready` sample, plus RESP.
- Memory handshake: `mem_req`, `mem_write`, `mem_addr`, `mem_wdata` are stable from assertion until the edge that samples `mem_ready`=1. `mem_req` drops (or switches to the refill request) after that edge.
- Reset mid-operation: asserting `reset_n` forces all outputs to 0 immediately. Any in-flight memory transaction is abandoned and dirty data is discarded.

## Configuration
- `CACHE_STATS_EN` defined:
  - Adds outputs `hit_count` and `miss_count`, 16 bits each, reset 0.
  - The matching counter increments on each RESP cycle and saturates at 0xFFFF.
- `CACHE_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
All scenarios use default parameters.
- Read miss then hit: after reset, read 0x03 with `mem_ready` at +2 and `mem_rdata`=0x15.
  - Expect one refill at `mem_addr` 0x03, then `cpu_ready` with `hit`=0 and `cpu_rdata`=0x15.
  - Reread 0x03: `hit`=1, 0x15, `cpu_ready` two edges after accept, no `mem_req`.
- LRU and write-back: read 0x03, read 0x05, write 0x03←0x0A (hit), then read 0x07.
  - Read 0x07 evicts clean 0x05: refill only.
  - Then read 0x09: write-back of 0x0A to 0x03, then refill of 0x09.
- Write miss into an invalid way: after reset, write 0x12←0x1F.
  - Expect no `mem_req`, `hit`=0.
  - Read 0x12: `hit`=1, `cpu_rdata`=0x1F.
- Stalled memory: hold `mem_ready`=0 for 5 cycles during a refill.
  - `mem_req`/`mem_addr` stay stable throughout.
  - `cpu_req` pulses during the stall are ignored, and exactly one `cpu_ready` results.
- Reset during WRITEBACK: pull `reset_n` low mid-transaction.
  - `mem_req` drops asynchronously and all outputs are 0.
  - A subsequent read of the evicted address misses.
- `CACHE_STATS_EN`: after the first scenario, `hit_count`=1 and `miss_count`=1.
  - Force `hit_count` to 0xFFFF; one more hit keeps it at 0xFFFF.
